// File: rtl/sram_seq.sv
// Cycle sequencer for an external async SRAM: one read or write at a time,
// with programmable setup, strobe and hold timing on CE/OE/WE.
module sram_seq #(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 8,
  parameter int SETUP  = 1,
  parameter int WAIT   = 3,
  parameter int HOLD   = 1
) (
  input  logic              clk,
  input  logic              resetq,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dout,
  output logic              sram_doe,
  input  logic [DATA_W-1:0] sram_din,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD
  } state_t;

  // Counter reload values: a phase of N cycles counts N-1 down to 0.
  localparam logic [7:0] C_SETUP = 8'(SETUP - 1);
  localparam logic [7:0] C_WAIT  = 8'(WAIT - 1);
  localparam logic [7:0] C_HOLD  = 8'((HOLD > 0) ? HOLD - 1 : 0);
  localparam bit         HAS_HOLD = (HOLD > 0);

  state_t              r_state;
  logic [7:0]          r_cnt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_dout;
  logic                r_doe;
  logic                r_ce_n;
  logic                r_oe_n;
  logic                r_we_n;
  logic                r_rd_valid;
  logic [DATA_W-1:0]   r_rd_data;
  logic                w_idle;
  logic                w_last;

  assign w_idle = (r_state == S_IDLE);
  assign w_last = (r_cnt == 8'd0);

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_dout     <= '0;
      r_doe      <= 1'b0;
      r_ce_n     <= 1'b1;
      r_oe_n     <= 1'b1;
      r_we_n     <= 1'b1;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_addr  <= cmd_addr;
            r_dout  <= cmd_wdata;
            r_we    <= cmd_we;
            r_doe   <= cmd_we;
            r_ce_n  <= 1'b0;
            r_cnt   <= C_SETUP;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (w_last) begin
            r_we_n  <= !r_we;
            r_oe_n  <= r_we;
            r_cnt   <= C_WAIT;
            r_state <= S_STROBE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_STROBE: begin
          if (w_last) begin
            r_we_n <= 1'b1;
            r_oe_n <= 1'b1;
            if (!r_we) begin
              r_rd_data  <= sram_din;
              r_rd_valid <= 1'b1;
            end
            // Without a hold phase the bus is released straight away.
            if (HAS_HOLD) begin
              r_cnt   <= C_HOLD;
              r_state <= S_HOLD;
            end else begin
              r_ce_n  <= 1'b1;
              r_doe   <= 1'b0;
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_HOLD: begin
          if (w_last) begin
            r_ce_n  <= 1'b1;
            r_doe   <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: begin
          r_ce_n  <= 1'b1;
          r_oe_n  <= 1'b1;
          r_we_n  <= 1'b1;
          r_doe   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = w_idle;
  assign busy      = !w_idle;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign sram_addr = r_addr;
  assign sram_dout = r_dout;
  assign sram_doe  = r_doe;
  assign sram_ce_n = r_ce_n;
  assign sram_oe_n = r_oe_n;
  assign sram_we_n = r_we_n;

endmodule

// File: tb/tb_sram_seq.sv
// Directed bench for sram_seq: default timing instance plus a
// WAIT=1/HOLD=0 instance sharing clock and reset.
module tb_sram_seq;

  logic        clk = 1'b0;
  logic        resetq = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [20:0] cmd_addr = '0;
  logic [7:0]  cmd_wdata = '0;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        busy;
  logic [20:0] sram_addr;
  logic [7:0]  sram_dout;
  logic        sram_doe;
  logic [7:0]  sram_din;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic [7:0]  din_val = 8'h00;

  logic        v_valid = 1'b0;
  logic        v_ready;
  logic        v_we = 1'b0;
  logic [20:0] v_addr = '0;
  logic [7:0]  v_wdata = '0;
  logic        v_rd_valid;
  logic [7:0]  v_rd_data;
  logic        v_busy;
  logic [20:0] v_sram_addr;
  logic [7:0]  v_sram_dout;
  logic        v_doe;
  logic [7:0]  v_din;
  logic        v_ce_n;
  logic        v_oe_n;
  logic        v_we_n;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  logic [7:0]  wr_data = '0;
  logic [20:0] wr_addr = '0;

  always #5 clk = ~clk;

  sram_seq dut (
    .clk(clk), .resetq(resetq),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy),
    .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_doe(sram_doe),
    .sram_din(sram_din), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  sram_seq #(.SETUP(1), .WAIT(1), .HOLD(0)) dut2 (
    .clk(clk), .resetq(resetq),
    .cmd_valid(v_valid), .cmd_ready(v_ready),
    .cmd_we(v_we), .cmd_addr(v_addr), .cmd_wdata(v_wdata),
    .rd_valid(v_rd_valid), .rd_data(v_rd_data), .busy(v_busy),
    .sram_addr(v_sram_addr), .sram_dout(v_sram_dout), .sram_doe(v_doe),
    .sram_din(v_din), .sram_ce_n(v_ce_n),
    .sram_oe_n(v_oe_n), .sram_we_n(v_we_n)
  );

  // The SRAM model only drives data while it is selected and output-enabled.
  assign sram_din = (!sram_ce_n && !sram_oe_n) ? din_val : 8'h00;
  assign v_din    = (!v_ce_n && !v_oe_n) ? 8'h96 : 8'h00;

  always @(posedge clk) begin
    if (resetq && !sram_ce_n && !sram_we_n) begin
      wr_cnt  <= wr_cnt + 1;
      wr_data <= sram_dout;
      wr_addr <= sram_addr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_doe, rd_valid} !== 5'b11100) begin
      failures++;
      $display("FAIL reset_strobes got=%b exp=11100",
               {sram_ce_n, sram_oe_n, sram_we_n, sram_doe, rd_valid});
    end
    checks++;
    if ({sram_addr, sram_dout, rd_data} !== 37'd0) begin
      failures++;
      $display("FAIL reset_regs addr=%h dout=%h rd_data=%h exp 0",
               sram_addr, sram_dout, rd_data);
    end
    resetq = 1'b1;
    tick();
    checks++;
    if ({cmd_ready, busy} !== 2'b10) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=10", {cmd_ready, busy});
    end
  endtask

  task automatic test_write();
    int w0;
    logic [6:0] exp;
    logic [6:0] got;
    w0 = wr_cnt;
    cmd_valid = 1'b1;
    cmd_we    = 1'b1;
    cmd_addr  = 21'h1ABCD;
    cmd_wdata = 8'h5A;
    tick();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c == 2) begin
        cmd_addr  = 21'h00FFF;
        cmd_wdata = 8'hEE;
      end
      exp = {c == 6, 1'b1, !(c >= 2 && c <= 4), c <= 5, c == 6, c != 6, 1'b0};
      got = {sram_ce_n, sram_oe_n, sram_we_n, sram_doe, cmd_ready, busy, rd_valid};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL write_cyc%0d ce/oe/we/doe/rdy/busy/rv got=%b exp=%b",
                 c, got, exp);
      end
      checks++;
      if ({sram_addr, sram_dout} !== {21'h1ABCD, 8'h5A}) begin
        failures++;
        $display("FAIL write_hold_cyc%0d addr=%h dout=%h exp 1abcd/5a",
                 c, sram_addr, sram_dout);
      end
      if (c < 6) tick();
    end
    checks++;
    if (wr_cnt - w0 != 3 || wr_data !== 8'h5A || wr_addr !== 21'h1ABCD) begin
      failures++;
      $display("FAIL write_model strobes=%0d data=%h addr=%h exp 3/5a/1abcd",
               wr_cnt - w0, wr_data, wr_addr);
    end
  endtask

  task automatic test_read();
    int w0;
    logic [6:0] exp;
    logic [6:0] got;
    w0 = wr_cnt;
    din_val   = 8'hC3;
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_addr  = 21'h00010;
    tick();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      exp = {c == 6, !(c >= 2 && c <= 4), 1'b1, 1'b0, c == 6, c != 6, c == 5};
      got = {sram_ce_n, sram_oe_n, sram_we_n, sram_doe, cmd_ready, busy, rd_valid};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL read_cyc%0d ce/oe/we/doe/rdy/busy/rv got=%b exp=%b",
                 c, got, exp);
      end
      checks++;
      if (rd_data !== ((c >= 5) ? 8'hC3 : 8'h00)) begin
        failures++;
        $display("FAIL read_data_cyc%0d got=%h exp=%h",
                 c, rd_data, (c >= 5) ? 8'hC3 : 8'h00);
      end
      if (c < 6) tick();
    end
    din_val = 8'h00;
    for (int c = 7; c <= 20; c++) tick();
    checks++;
    if (rd_data !== 8'hC3 || wr_cnt != w0) begin
      failures++;
      $display("FAIL read_retain rd_data=%h writes=%0d exp c3/0",
               rd_data, wr_cnt - w0);
    end
  endtask

  task automatic test_back_to_back();
    int ce_hi;
    int n;
    int pulses;
    din_val   = 8'h3C;
    cmd_valid = 1'b1;
    cmd_we    = 1'b1;
    cmd_addr  = 21'h00200;
    cmd_wdata = 8'h11;
    tick();
    cmd_we   = 1'b0;
    cmd_addr = 21'h00300;
    ce_hi = 0;
    for (int c = 1; c <= 6; c++) begin
      if (sram_ce_n) ce_hi++;
      checks++;
      if ({cmd_ready, sram_addr} !== {c == 6, 21'h00200}) begin
        failures++;
        $display("FAIL b2b_busy_cyc%0d ready=%b addr=%h exp %b/00200",
                 c, cmd_ready, sram_addr, c == 6);
      end
      tick();
    end
    cmd_valid = 1'b0;
    checks++;
    if (ce_hi != 1 || sram_ce_n !== 1'b0 || sram_addr !== 21'h00300 || sram_doe !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second_accept ce_gap=%0d ce_n=%b addr=%h doe=%b exp 1/0/00300/0",
               ce_hi, sram_ce_n, sram_addr, sram_doe);
    end
    n = 0;
    pulses = 0;
    while (!cmd_ready && n < 50) begin
      if (rd_valid) pulses++;
      tick();
      n++;
    end
    checks++;
    if (n != 5 || pulses != 1 || rd_data !== 8'h3C) begin
      failures++;
      $display("FAIL b2b_read cycles=%0d pulses=%0d rd_data=%h exp 5/1/3c",
               n, pulses, rd_data);
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({sram_ce_n, cmd_ready} !== 2'b11) begin
        failures++;
        $display("FAIL b2b_no_dup idle%0d ce_n/ready got=%b exp=11",
                 c, {sram_ce_n, cmd_ready});
      end
      tick();
    end
    din_val = 8'h00;
  endtask

  task automatic test_reset_mid();
    din_val   = 8'hA5;
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_addr  = 21'h00040;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (sram_oe_n !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_pre oe_n got=%b exp=0", sram_oe_n);
    end
    resetq = 1'b0;
    #1;
    checks++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_doe} !== 4'b1110 || sram_addr !== 21'd0) begin
      failures++;
      $display("FAIL rstmid_async ce/oe/we/doe got=%b addr=%h exp 1110/0",
               {sram_ce_n, sram_oe_n, sram_we_n, sram_doe}, sram_addr);
    end
    tick();
    tick();
    resetq = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if ({rd_valid, cmd_ready, sram_ce_n} !== 3'b011 || rd_data !== 8'h00) begin
        failures++;
        $display("FAIL rstmid_after%0d rv/rdy/ce_n=%b rd_data=%h exp 011/00",
                 c, {rd_valid, cmd_ready, sram_ce_n}, rd_data);
      end
    end
    din_val = 8'h00;
  endtask

  task automatic test_short_read();
    logic [5:0] exp;
    logic [5:0] got;
    v_valid = 1'b1;
    v_we    = 1'b0;
    v_addr  = 21'h1FFFFF;
    tick();
    v_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      exp = {c >= 3, c != 2, 1'b1, 1'b0, c >= 3, c == 3};
      got = {v_ce_n, v_oe_n, v_we_n, v_doe, v_ready, v_rd_valid};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL short_cyc%0d ce/oe/we/doe/rdy/rv got=%b exp=%b",
                 c, got, exp);
      end
      if (c == 3) begin
        checks++;
        if (v_rd_data !== 8'h96 || v_sram_addr !== 21'h1FFFFF) begin
          failures++;
          $display("FAIL short_data rd_data=%h addr=%h exp 96/1fffff",
                   v_rd_data, v_sram_addr);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid();
    test_short_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
